// File: rtl/kernel_pingpong.sv
// rtl/kernel_pingpong.sv - ping-pong kernel store: stream fill into one bank, region replay from the other
// Optional status port: define KERNEL_STATUS_EN to add ker_status[4:0].
module kernel_pingpong #(
  parameter int CFG_DWIDTH    = 32,
  parameter int CFG_AWIDTH    = 5,
  parameter int CFG_KER_WR    = 2,
  parameter int CFG_KER_RD    = 3,
  parameter int STR_KER_WIDTH = 16,
  parameter int GROUP_NB      = 4,
  parameter int KER_WIDTH     = 16,
  parameter int DEPTH_NB      = 1,
  parameter int MEM_AWIDTH    = 8,
  parameter int MEM_DEPTH     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CFG_DWIDTH-1:0]                 cfg_data,
  input  logic [CFG_AWIDTH-1:0]                 cfg_addr,
  input  logic                                  cfg_valid,
  input  logic [STR_KER_WIDTH-1:0]              str_ker,
  input  logic                                  str_ker_val,
  output logic                                  str_ker_rdy,
  output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] kernel,
  output logic                                  kernel_val,
`ifdef KERNEL_STATUS_EN
  output logic [4:0]                            ker_status,
`endif
  input  logic                                  kernel_rdy
);

  localparam int W     = GROUP_NB * KER_WIDTH * DEPTH_NB;
  localparam int BEATS = W / STR_KER_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DA    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(MEM_DEPTH - 1);

  typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RUN} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [W-1:0]          mem [2][MEM_DEPTH];
  logic [1:0]            bank_full, full_nxt;
  logic                  wr_bank, rd_bank;

  logic [MEM_AWIDTH-1:0] wr_end, wr_addr, cfg_wr_end, wr_end_clamped;
  logic [BW-1:0]         beat_cnt;
  logic [W-1:0]          acc, word_asm;
  logic                  wr_cfg, wr_xfer, wr_word, wr_done;

  logic [MEM_AWIDTH-1:0] rd_start, rd_end, rd_addr, rd_next;
  logic                  rd_last, rd_done, kernel_rel;
  logic                  rd_cfg, rd_load, rd_accept, rd_release;
  logic                  cfg_unused;

  assign cfg_unused = ^cfg_data;

  assign wr_cfg  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_WR));
  assign rd_cfg  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_RD));

  assign str_ker_rdy = (wr_state == WR_FILL) && !bank_full[wr_bank];
  assign wr_xfer     = str_ker_val && str_ker_rdy;
  assign wr_word     = wr_xfer && (beat_cnt == BW'(BEATS - 1));
  assign wr_done     = wr_word && (wr_addr == wr_end);

  assign cfg_wr_end     = cfg_data[MEM_AWIDTH-1:0];
  assign wr_end_clamped = ({1'b0, cfg_wr_end} >= (MEM_AWIDTH+1)'(MEM_DEPTH)) ? LAST_ADDR : cfg_wr_end;

  // Beat k of a word lands at bit k*STR_KER_WIDTH, so beat 0 ends up in the LSBs
  always_comb begin
    word_asm = acc;
    word_asm[int'(beat_cnt)*STR_KER_WIDTH +: STR_KER_WIDTH] = str_ker;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_cfg) wr_state_nxt = WR_FILL;
      WR_FILL: if (wr_done) wr_state_nxt = WR_IDLE;
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_end   <= '0;
      wr_addr  <= '0;
      beat_cnt <= '0;
      acc      <= '0;
    end else if (wr_state == WR_IDLE && wr_cfg) begin
      wr_end   <= wr_end_clamped;
      wr_addr  <= '0;
      beat_cnt <= '0;
    end else if (wr_xfer) begin
      acc <= word_asm;
      if (beat_cnt == BW'(BEATS - 1)) begin
        beat_cnt <= '0;
        wr_addr  <= wr_addr + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_word) mem[wr_bank][wr_addr[DA-1:0]] <= word_asm;
  end

  assign rd_next    = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
  assign rd_accept  = kernel_val && kernel_rdy;
  // A restart never releases the bank, even if the end word is accepted that cycle
  assign rd_release = rd_accept && kernel_rel && !rd_cfg;
  assign rd_load    = (rd_state == RD_RUN) && !rd_done && !rd_cfg && (!kernel_val || kernel_rdy);

  always_comb begin
    rd_state_nxt = rd_state;
    if (rd_cfg) begin
      rd_state_nxt = RD_WAIT;
    end else begin
      case (rd_state)
        RD_IDLE: rd_state_nxt = RD_IDLE;
        RD_WAIT: if (bank_full[rd_bank]) rd_state_nxt = RD_RUN;
        RD_RUN:  if (rd_release) rd_state_nxt = RD_IDLE;
        default: rd_state_nxt = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  // Output register: a new word loads whenever the slot is empty or being accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      kernel     <= '0;
      kernel_val <= 1'b0;
      kernel_rel <= 1'b0;
      rd_done    <= 1'b0;
      rd_start   <= '0;
      rd_end     <= '0;
      rd_last    <= 1'b0;
      rd_addr    <= '0;
    end else if (rd_cfg) begin
      rd_start   <= cfg_data[MEM_AWIDTH-1:0];
      rd_end     <= cfg_data[16 +: MEM_AWIDTH];
      rd_last    <= cfg_data[15];
      rd_addr    <= cfg_data[MEM_AWIDTH-1:0];
      rd_done    <= 1'b0;
      kernel_val <= 1'b0;
      kernel_rel <= 1'b0;
    end else if (rd_load) begin
      kernel     <= mem[rd_bank][rd_addr[DA-1:0]];
      kernel_val <= 1'b1;
      kernel_rel <= rd_last && (rd_addr == rd_end);
      if (rd_addr == rd_end) begin
        rd_addr <= rd_start;
        rd_done <= rd_last;
      end else begin
        rd_addr <= rd_next;
      end
    end else if (rd_accept) begin
      kernel_val <= 1'b0;
      kernel_rel <= 1'b0;
    end
  end

  always_comb begin
    full_nxt = bank_full;
    if (rd_release) full_nxt[rd_bank] = 1'b0;
    if (wr_done)    full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      if (wr_done)    wr_bank <= ~wr_bank;
      if (rd_release) rd_bank <= ~rd_bank;
    end
  end

`ifdef KERNEL_STATUS_EN
  logic err;

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (str_ker_val && !str_ker_rdy && wr_state == WR_IDLE) err <= 1'b1;
  end

  assign ker_status = {err, rd_state == RD_RUN, wr_state == WR_FILL, bank_full};
`endif

endmodule
